// File: rtl/lii_tx_packetizer.sv
// rtl/lii_tx_packetizer.sv - LII transmit packetizer: command + payload words -> framed LII beats
module lii_tx_packetizer #(
    parameter int                DW       = 256,
    parameter int                SRC_W    = 8,
    parameter int                DST_W    = 8,
    parameter int                TYPE_W   = 2,
    parameter int                LEN_W    = 16,
    parameter logic [SRC_W-1:0]  LOCAL_ID = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DST_W-1:0]    cmd_dst,
    input  logic [TYPE_W-1:0]   cmd_type,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DW-1:0]       s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DW-1:0]       out_data,
    output logic [DW/8-1:0]     out_keep,
    output logic [DW/8-1:0]     out_strb,
    output logic                out_last,
    output logic [SRC_W-1:0]    out_src,
    output logic [DST_W-1:0]    out_dst,
    output logic [TYPE_W-1:0]   out_type,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                err_zero_len
);

    localparam int BYTES = DW / 8;
    localparam int RW    = $clog2(BYTES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DST_W-1:0]   dst_q;
    logic [TYPE_W-1:0]  type_q;
    logic [RW-1:0]      rem_q;
    logic [LEN_W-1:0]   remaining;

    logic               cmd_fire;
    logic               cmd_zero;
    logic               load;
    logic               last_load;
    logic [LEN_W:0]     len_round;
    logic [LEN_W-1:0]   cmd_beats;
    logic [BYTES-1:0]   load_keep;

    // One extra bit so a full-scale length cannot wrap before the divide
    assign len_round = {1'b0, cmd_len} + (LEN_W+1)'(BYTES - 1);
    assign cmd_beats = LEN_W'(len_round >> RW);

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign cmd_zero  = (cmd_len == '0);
    assign load      = s_valid & s_ready;
    assign last_load = (remaining == LEN_W'(1));
    assign load_keep = (last_load && rem_q != '0) ? ~({BYTES{1'b1}} << rem_q) : {BYTES{1'b1}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_fire && !cmd_zero) state_nxt = SEND;
            SEND: if (load && last_load)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            SEND: s_ready   = !out_valid | out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dst_q        <= '0;
            type_q       <= '0;
            rem_q        <= '0;
            remaining    <= '0;
            err_zero_len <= 1'b0;
            out_data     <= '0;
            out_keep     <= '0;
            out_last     <= 1'b0;
            out_dst      <= '0;
            out_type     <= '0;
            out_valid    <= 1'b0;
        end else begin
            err_zero_len <= cmd_fire & cmd_zero;
            if (cmd_fire && !cmd_zero) begin
                dst_q     <= cmd_dst;
                type_q    <= cmd_type;
                rem_q     <= cmd_len[RW-1:0];
                remaining <= cmd_beats;
            end
            // A load wins over an unload so a same-cycle swap keeps valid high
            if (load) begin
                remaining <= remaining - LEN_W'(1);
                out_data  <= s_data;
                out_keep  <= load_keep;
                out_last  <= last_load;
                out_dst   <= dst_q;
                out_type  <= type_q;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_strb = out_keep;
    assign out_src  = LOCAL_ID;
    assign busy     = (state == SEND) | out_valid;

endmodule

// File: tb/tb_lii_tx_packetizer.sv
// tb/tb_lii_tx_packetizer.sv - scoreboard bench for lii_tx_packetizer
module tb_lii_tx_packetizer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_dst;
    logic [1:0]   cmd_type;
    logic [15:0]  cmd_len;
    logic [255:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [255:0] out_data;
    logic [31:0]  out_keep;
    logic [31:0]  out_strb;
    logic         out_last;
    logic [7:0]   out_src;
    logic [7:0]   out_dst;
    logic [1:0]   out_type;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         err_zero_len;

    lii_tx_packetizer #(.DW(256), .SRC_W(8), .DST_W(8), .TYPE_W(2), .LEN_W(16), .LOCAL_ID(8'h05)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst(cmd_dst), .cmd_type(cmd_type), .cmd_len(cmd_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .out_data(out_data), .out_keep(out_keep), .out_strb(out_strb), .out_last(out_last),
        .out_src(out_src), .out_dst(out_dst), .out_type(out_type),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err_zero_len(err_zero_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [7:0]   dst;
        logic [1:0]   typ;
    } beat_t;

    beat_t        sb[$];
    int           hs_cyc[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           stall_cnt = 0;
    int           sready_lat = 0;
    logic         held_v = 1'b0;
    logic [255:0] held_data;
    logic [31:0]  held_keep;
    logic         held_last;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag, input int waited);
        total++;
        bad++;
        $error("FAIL %s timeout observed=%0d cycles expected=handshake", tag, waited);
    endtask

    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Scoreboard consumer plus stall-stability watcher
    always @(negedge clk) begin
        beat_t e;
        if (held_v) begin
            check("stall_data", out_data, held_data);
            check("stall_keep", out_keep, held_keep);
            check("stall_last", out_last, held_last);
        end
        held_v = out_valid && !out_ready;
        if (held_v) begin
            stall_cnt++;
            held_data = out_data;
            held_keep = out_keep;
            held_last = out_last;
            check("sready_stall", s_ready, 1'b0);
        end
        if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_beat observed=%0h expected=none", out_data);
            end else begin
                e = sb.pop_front();
                check("data", out_data, e.data);
                check("keep", out_keep, e.keep);
                check("strb", out_strb, e.keep);
                check("last", out_last, e.last);
                check("src", out_src, 8'h05);
                check("dst", out_dst, e.dst);
                check("type", out_type, e.typ);
            end
        end
    end

    // Starts at posedge+1; returns at posedge+1 after the last payload handshake
    task automatic send_pkt(input int len, input logic [7:0] dst, input logic [1:0] typ);
        int n;
        int waitc;
        int rem;
        beat_t b;
        n = (len + 31) / 32;
        rem = len % 32;
        cmd_valid = 1'b1;
        cmd_dst = dst;
        cmd_type = typ;
        cmd_len = len[15:0];
        waitc = 0;
        @(negedge clk);
        while (!cmd_ready) begin
            waitc++;
            if (waitc > 200) begin timeout("cmd_hs", waitc); cmd_valid = 1'b0; return; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        sready_lat = 0;
        for (int i = 0; i < n; i++) begin
            b.data = rnd_word();
            b.last = (i == n - 1);
            b.keep = (b.last && rem != 0) ? ((32'h1 << rem) - 32'h1) : 32'hFFFF_FFFF;
            b.dst = dst;
            b.typ = typ;
            sb.push_back(b);
            s_valid = 1'b1;
            s_data = b.data;
            waitc = 0;
            @(negedge clk);
            while (!s_ready) begin
                waitc++;
                if (i == 0) sready_lat++;
                if (waitc > 200) begin timeout("payload_hs", waitc); return; end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            waitc++;
            if (waitc > 200) begin timeout("drain", waitc); sb.delete(); return; end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int sbase;
        int waitc;
        logic [255:0] w;
        beat_t b;
        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_dst = '0;
        cmd_type = '0;
        cmd_len = '0;
        s_data = '0;
        s_valid = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_keep", out_keep, 32'h0);
        check("rst_out_dst", out_dst, 8'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_err", err_zero_len, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single full beat
        send_pkt(32, 8'h80, 2'd1);
        check("lat_cmd_to_sready", sready_lat, 0);
        s_valid = 1'b0;
        drain();

        // Three beats with partial tail
        send_pkt(70, 8'h21, 2'd2);
        s_valid = 1'b0;
        drain();

        // Same shape with beat B stalled for 3 cycles
        base = hs_cyc.size();
        sbase = stall_cnt;
        fork
            send_pkt(70, 8'h33, 2'd3);
            begin
                waitc = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (out_valid && hs_cyc.size() == base + 1) break;
                    waitc++;
                    if (waitc > 100) begin timeout("stall_wait", waitc); break; end
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        s_valid = 1'b0;
        drain();
        check("stall_cycles", stall_cnt - sbase, 3);
        check("stall_beats", hs_cyc.size() - base, 3);

        // Zero-length command
        cmd_valid = 1'b1;
        cmd_len = 16'd0;
        @(negedge clk);
        check("zl_cmd_ready", cmd_ready, 1'b1);
        check("zl_err_before", err_zero_len, 1'b0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("zl_err_pulse", err_zero_len, 1'b1);
        check("zl_out_valid", out_valid, 1'b0);
        check("zl_cmd_ready_after", cmd_ready, 1'b1);
        @(negedge clk);
        check("zl_err_clear", err_zero_len, 1'b0);
        check("zl_out_valid2", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back, s_valid held high
        base = hs_cyc.size();
        send_pkt(64, 8'h44, 2'd0);
        send_pkt(1, 8'h55, 2'd1);
        check("b2b_sready_lat", sready_lat, 0);
        s_valid = 1'b0;
        drain();
        if (hs_cyc.size() == base + 3) begin
            check("b2b_gap_in_pkt", hs_cyc[base+1] - hs_cyc[base], 1);
            check("b2b_gap_between", hs_cyc[base+2] - hs_cyc[base+1], 2);
        end else begin
            check("b2b_beat_count", hs_cyc.size() - base, 3);
        end

        // Reset in the middle of a 3-beat packet
        cmd_valid = 1'b1;
        cmd_dst = 8'h66;
        cmd_type = 2'd2;
        cmd_len = 16'd96;
        for (int i = 0; i < 3; i++) begin
            b.data = rnd_word();
            b.keep = 32'hFFFF_FFFF;
            b.last = (i == 2);
            b.dst = 8'h66;
            b.typ = 2'd2;
            sb.push_back(b);
        end
        w = sb[0].data;
        s_valid = 1'b1;
        s_data = w;
        @(negedge clk);
        check("mr_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 s_data = sb[1].data;
        @(posedge clk);
        #1;
        check("mr_out_valid_before", out_valid, 1'b1);
        rstn = 1'b0;
        s_valid = 1'b0;
        #1;
        check("mr_out_valid_async", out_valid, 1'b0);
        check("mr_cmd_ready_rst", cmd_ready, 1'b1);
        check("mr_busy_rst", busy, 1'b0);
        check("mr_beats_before_rst", sb.size(), 2);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("mr_idle_cmd_ready", cmd_ready, 1'b1);
        check("mr_idle_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        send_pkt(32, 8'h77, 2'd3);
        s_valid = 1'b0;
        drain();
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lii_tx_packetizer.md
Name: lii_tx_packetizer

Overview:
- Transmit-side endpoint for the LII fabric: turns a per-packet command (dst, type, byte length) and an unframed payload word stream into framed LII beats.
- Framing covers src, dst, type, keep, strb and last; the beats feed one router input port.
- Sits between a compute/DMA client and the router. Owns beat counting, final-beat keep generation and a registered output stage with full valid/ready backpressure.

Parameters:
- DW, 256, data width in bits; BYTES = DW/8.
- SRC_W, 8, source ID width.
- DST_W, 8, destination ID width.
- TYPE_W, 2, packet type width.
- LEN_W, 16, command byte-length width.
- LOCAL_ID, 0, value driven on out_src for every beat.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  packet command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_dst  in  DST_W  destination ID.
- cmd_type  in  TYPE_W  packet type.
- cmd_len  in  LEN_W  payload length in bytes.
- s_data  in  DW  payload word; byte 0 = s_data[7:0].
- s_valid  in  1  payload word valid.
- s_ready  out  1  payload word accepted when s_valid & s_ready.
- out_data  out  DW  LII data.
- out_keep  out  BYTES  LII keep.
- out_strb  out  BYTES  LII strobe, always equal to out_keep.
- out_last  out  1  final beat of packet.
- out_src  out  SRC_W  source ID = LOCAL_ID.
- out_dst  out  DST_W  latched cmd_dst.
- out_type  out  TYPE_W  latched cmd_type.
- out_valid  out  1  LII valid.
- out_ready  in  1  LII ready.
- busy  out  1  high in SEND or while out_valid.
- err_zero_len  out  1  one-cycle pulse on acceptance of a cmd_len==0 command.

Behaviour:
- Reset (async assert, sync release): state=IDLE. out_valid=0, out_last=0, out_data/keep/strb/dst/type=0, beat counter=0, err_zero_len=0, cmd_ready=1 (IDLE), s_ready=0.
- FSM states:
  - IDLE: cmd_ready=1, s_ready=0.
    - On command handshake with cmd_len!=0: latch dst, type and len. Compute beats = ceil(cmd_len/BYTES), rem = cmd_len mod BYTES. Go to SEND.
    - On command handshake with cmd_len==0: pulse err_zero_len next cycle, emit nothing, stay IDLE.
  - SEND: cmd_ready=0, s_ready = (!out_valid | out_ready).
    - Each payload handshake loads the output register next edge: out_data=s_data, out_valid=1, dst/type from latch, out_last=(remaining==1), out_keep=all ones except on the last beat.
    - On the last beat with rem!=0, out_keep = (1<<rem)-1.
    - Remaining count decrements per handshake. When the last beat is loaded, go to IDLE.
- Output register:
  - out_valid clears on out_ready with no new load.
  - A simultaneous unload and load keeps out_valid=1 with the new beat; full throughput is 1 beat/cycle.
  - All out_* are stable while out_valid & !out_ready.
- Latency:
  - command handshake to first s_ready: 1 cycle.
  - payload handshake to out_valid: 1 cycle.
  - Minimum gap between packets: 1 idle cycle for the command handshake. The next command may be accepted while the previous last beat still waits in the output register.
- Width rules:
  - beats computed in LEN_W bits; ceil via (len + BYTES-1) >> log2(BYTES).
  - BYTES must be a power of two.
  - len = 2^LEN_W-1 must not overflow; use an LEN_W+1 bit intermediate.
- Payload words are never consumed in IDLE. Extra words stay on s_data until the next packet.
- Reset mid-packet: all in-flight state is discarded, out_valid drops immediately, and no partial last is emitted.

Test Plan (DW=256, BYTES=32, LOCAL_ID=8'h05):
- cmd_len=32, dst=8'h80, type=1, one payload word -> one beat: out_last=1, keep=32'hFFFFFFFF, out_src=8'h05, out_dst=8'h80, out_type=1.
- cmd_len=70, three words A,B,C -> beats A,B,C; last only on C; keep FFFFFFFF, FFFFFFFF, 0000003F; strb identical to keep.
- Same as previous with out_ready low for 3 cycles during beat B -> beat B held stable; s_ready=0 while the register is full and stalled; no word lost or duplicated.
- cmd_len=0 -> err_zero_len high exactly 1 cycle; out_valid never asserts; cmd_ready stays 1.
- Back-to-back commands (len=64, then len=1), s_valid always high, out_ready always high -> 2 beats + 1 beat. Second packet keep=00000001. Exactly one idle output cycle between packets.
- Assert rstn low after beat 1 of a 3-beat packet -> out_valid=0 asynchronously. After release: IDLE, cmd_ready=1, and a new len=32 packet emits correctly.
